// File: rtl/ysyx_22040237_mem_arb_pkg.sv
// rtl/ysyx_22040237_mem_arb_pkg.sv - shared state and owner encodings for the memory arbiter
// Purpose: FSM state encodings and owner codes shared by the arbiter top and winner picker.
// Ports: none (package).
package ysyx_22040237_mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } arb_state_e;

    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_LS = 1'b1;

endpackage

// File: rtl/ysyx_22040237_arb_pick.sv
// rtl/ysyx_22040237_arb_pick.sv - combinational winner selection between IF and LS requesters
// Purpose: pick which requester is granted when the arbiter is idle.
// Ports: i_if_valid/i_ls_valid request valids, i_last_grant previous owner,
//        o_winner selected owner code, o_grant_any high when any requester is valid.
module ysyx_22040237_arb_pick
    import ysyx_22040237_mem_arb_pkg::*;
(
    input  logic i_if_valid,
    input  logic i_ls_valid,
    input  logic i_last_grant,
    output logic o_winner,
    output logic o_grant_any
);

    // On contention the requester that did not win last time is chosen. A
    // caller that ties i_last_grant to OWNER_IF therefore gets fixed LS priority.
    always_comb begin
        o_grant_any = i_if_valid | i_ls_valid;
        if (i_if_valid && i_ls_valid) begin
            o_winner = ~i_last_grant;
        end else if (i_ls_valid) begin
            o_winner = OWNER_LS;
        end else begin
            o_winner = OWNER_IF;
        end
    end

endmodule

// File: rtl/ysyx_22040237_mem_arb.sv
// rtl/ysyx_22040237_mem_arb.sv - single-outstanding arbiter sharing one memory port between IF and LS
// Purpose: accept one request at a time from fetch (IF) or load/store (LS), issue it on the
//          memory port, and route the memory response back to the requester that owns it.
// Ports: clk/rst (sync, active-high); if_req_*/if_addr, if_rsp_valid/if_rdata fetch side;
//        ls_req_*/ls_addr/ls_wen/ls_wdata/ls_wmask, ls_rsp_valid/ls_rdata load/store side;
//        mem_req_*/mem_addr/mem_wen/mem_wdata/mem_wmask, mem_rsp_valid/mem_rdata memory side;
//        busy high whenever a transaction is in flight.
// Config: define YSYX_22040237_ARB_RR_EN for round-robin on contention (default: LS priority).
module ysyx_22040237_mem_arb
    import ysyx_22040237_mem_arb_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                if_req_valid,
    output logic                if_req_ready,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_rsp_valid,
    output logic [DATA_W-1:0]   if_rdata,

    input  logic                ls_req_valid,
    output logic                ls_req_ready,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic                ls_wen,
    input  logic [DATA_W-1:0]   ls_wdata,
    input  logic [DATA_W/8-1:0] ls_wmask,
    output logic                ls_rsp_valid,
    output logic [DATA_W-1:0]   ls_rdata,

    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rdata,

    output logic                busy
);

    arb_state_e          r_state;
    logic                r_owner;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_wen;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W/8-1:0] r_wmask;

    logic w_winner;
    logic w_grant_any;
    logic w_last_grant;
    logic w_idle;
    logic w_rsp;

    ysyx_22040237_arb_pick u_pick (
        .i_if_valid   (if_req_valid),
        .i_ls_valid   (ls_req_valid),
        .i_last_grant (w_last_grant),
        .o_winner     (w_winner),
        .o_grant_any  (w_grant_any)
    );

`ifdef YSYX_22040237_ARB_RR_EN
    logic r_last_grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= OWNER_IF;
        end else if (w_idle && w_grant_any) begin
            r_last_grant <= w_winner;
        end
    end

    assign w_last_grant = r_last_grant;
`else
    // Pinning the picker's history to IF makes it always hand contention to LS.
    assign w_last_grant = OWNER_IF;
`endif

    // Outputs are masked by rst so they read zero in the reset cycle itself,
    // before the registered state has had an edge to clear.
    assign w_idle = (r_state == ST_IDLE) && !rst;
    assign w_rsp  = (r_state == ST_WAIT) && mem_rsp_valid && !rst;

    assign if_req_ready = w_idle && if_req_valid && (w_winner == OWNER_IF);
    assign ls_req_ready = w_idle && ls_req_valid && (w_winner == OWNER_LS);

    assign if_rsp_valid = w_rsp && (r_owner == OWNER_IF);
    assign ls_rsp_valid = w_rsp && (r_owner == OWNER_LS);
    assign if_rdata     = if_rsp_valid ? mem_rdata : '0;
    assign ls_rdata     = ls_rsp_valid ? mem_rdata : '0;

    assign mem_req_valid = (r_state == ST_REQ) && !rst;
    assign busy          = (r_state != ST_IDLE) && !rst;
    assign mem_addr      = rst ? '0 : r_addr;
    assign mem_wen       = rst ? 1'b0 : r_wen;
    assign mem_wdata     = rst ? '0 : r_wdata;
    assign mem_wmask     = rst ? '0 : r_wmask;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_owner <= OWNER_IF;
            r_addr  <= '0;
            r_wen   <= 1'b0;
            r_wdata <= '0;
            r_wmask <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_any) begin
                        r_state <= ST_REQ;
                        r_owner <= w_winner;
                        if (w_winner == OWNER_LS) begin
                            r_addr  <= ls_addr;
                            r_wen   <= ls_wen;
                            r_wdata <= ls_wdata;
                            r_wmask <= ls_wmask;
                        end else begin
                            // Fetches are always reads with no byte lanes enabled.
                            r_addr  <= if_addr;
                            r_wen   <= 1'b0;
                            r_wdata <= '0;
                            r_wmask <= '0;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready) begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_rsp_valid) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22040237_mem_arb.sv
// tb/tb_ysyx_22040237_mem_arb.sv - self-checking bench for the IF/LS memory arbiter
module tb_ysyx_22040237_mem_arb;
    import ysyx_22040237_mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_valid, if_req_ready, if_rsp_valid;
    logic [63:0] if_addr, if_rdata;
    logic        ls_req_valid, ls_req_ready, ls_wen, ls_rsp_valid;
    logic [63:0] ls_addr, ls_wdata, ls_rdata;
    logic [7:0]  ls_wmask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid, busy;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;

    typedef struct {
        logic        owner;
        logic [63:0] rdata;
    } rsp_t;

    rsp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    logic seq [4];

    always #5 clk = ~clk;

    ysyx_22040237_mem_arb #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_rsp_valid(if_rsp_valid), .if_rdata(if_rdata),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
        .ls_wen(ls_wen), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
        .ls_rsp_valid(ls_rsp_valid), .ls_rdata(ls_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".if_req_ready"}, if_req_ready, 0);
        chk({tag, ".ls_req_ready"}, ls_req_ready, 0);
        chk({tag, ".if_rsp_valid"}, if_rsp_valid, 0);
        chk({tag, ".ls_rsp_valid"}, ls_rsp_valid, 0);
        chk({tag, ".if_rdata"}, if_rdata, 0);
        chk({tag, ".ls_rdata"}, ls_rdata, 0);
        chk({tag, ".mem_req_valid"}, mem_req_valid, 0);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".mem_wen"}, mem_wen, 0);
        chk({tag, ".mem_addr"}, mem_addr, 0);
        chk({tag, ".mem_wdata"}, mem_wdata, 0);
        chk({tag, ".mem_wmask"}, mem_wmask, 0);
    endtask

    // Runs one transaction starting in IDLE with the request already driven.
    task automatic txn(input string tag, input logic owner, input logic [63:0] addr,
                       input logic wen, input logic [63:0] wdata, input logic [7:0] wmask,
                       input logic [63:0] rdata, input int stall, input bit drop);
        rsp_t e;
        e.owner = owner;
        e.rdata = rdata;
        exp_q.push_back(e);
        chk({tag, ".accept_if_ready"}, if_req_ready, owner == OWNER_IF);
        chk({tag, ".accept_ls_ready"}, ls_req_ready, owner == OWNER_LS);
        tick();
        if (drop) begin
            if (owner == OWNER_IF) if_req_valid = 1'b0;
            else ls_req_valid = 1'b0;
        end
        for (int i = 0; i <= stall; i++) begin
            // A stray response while the request is still pending must be ignored.
            mem_rsp_valid = 1'b1;
            mem_rdata     = 64'hBAD0_0000 + 64'(i);
            mem_req_ready = (i == stall);
            settle();
            chk({tag, ".req_valid"}, mem_req_valid, 1);
            chk({tag, ".req_addr"}, mem_addr, addr);
            chk({tag, ".req_wen"}, mem_wen, wen);
            chk({tag, ".req_wmask"}, mem_wmask, wmask);
            if (owner == OWNER_LS) chk({tag, ".req_wdata"}, mem_wdata, wdata);
            chk({tag, ".req_busy"}, busy, 1);
            chk({tag, ".req_if_ready"}, if_req_ready, 0);
            chk({tag, ".req_ls_ready"}, ls_req_ready, 0);
            chk({tag, ".req_if_rsp"}, if_rsp_valid, 0);
            chk({tag, ".req_ls_rsp"}, ls_rsp_valid, 0);
            tick();
        end
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rdata     = rdata;
        settle();
        chk({tag, ".wait_req_valid"}, mem_req_valid, 0);
        chk({tag, ".wait_busy"}, busy, 1);
        e = exp_q.pop_front();
        if (e.owner == OWNER_IF) begin
            chk({tag, ".if_rsp_valid"}, if_rsp_valid, 1);
            chk({tag, ".if_rdata"}, if_rdata, e.rdata);
            chk({tag, ".ls_rsp_valid"}, ls_rsp_valid, 0);
            chk({tag, ".ls_rdata"}, ls_rdata, 0);
        end else begin
            chk({tag, ".ls_rsp_valid"}, ls_rsp_valid, 1);
            chk({tag, ".ls_rdata"}, ls_rdata, e.rdata);
            chk({tag, ".if_rsp_valid"}, if_rsp_valid, 0);
            chk({tag, ".if_rdata"}, if_rdata, 0);
        end
        tick();
        mem_rsp_valid = 1'b0;
        mem_rdata     = '0;
        settle();
        chk({tag, ".idle_busy"}, busy, 0);
    endtask

    initial begin
        rst = 1'b1;
        if_req_valid = 1'b1; if_addr = 64'h8000_0000;
        ls_req_valid = 1'b0; ls_addr = '0; ls_wen = 1'b0; ls_wdata = '0; ls_wmask = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
        repeat (3) tick();
        settle();
        chk_zero("in_reset");
        if_req_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        settle();
        chk_zero("after_reset");

        // IF only, minimum latency
        if_addr = 64'h8000_0000; if_req_valid = 1'b1;
        settle();
        txn("if_only", OWNER_IF, 64'h8000_0000, 0, 0, 0, 64'h13, 0, 1);

        // IF and LS store together: LS first, IF right after the LS response
        ls_addr = 64'h8000_1000; ls_wen = 1'b1; ls_wdata = 64'hDEAD; ls_wmask = 8'hFF;
        ls_req_valid = 1'b1;
        if_addr = 64'h8000_0004; if_req_valid = 1'b1;
        settle();
        txn("both_ls", OWNER_LS, 64'h8000_1000, 1, 64'hDEAD, 8'hFF, 64'h1111, 0, 1);
        txn("both_if", OWNER_IF, 64'h8000_0004, 0, 0, 0, 64'h2222, 0, 1);

        // Both held valid for four transactions
`ifdef YSYX_22040237_ARB_RR_EN
        seq[0] = OWNER_LS; seq[1] = OWNER_IF; seq[2] = OWNER_LS; seq[3] = OWNER_IF;
`else
        seq[0] = OWNER_LS; seq[1] = OWNER_LS; seq[2] = OWNER_LS; seq[3] = OWNER_LS;
`endif
        ls_addr = 64'h8000_2000; ls_wen = 1'b0; ls_wdata = '0; ls_wmask = '0;
        if_addr = 64'h8000_0100;
        ls_req_valid = 1'b1; if_req_valid = 1'b1;
        settle();
        for (int i = 0; i < 4; i++) begin
            if (seq[i] == OWNER_LS)
                txn("held_ls", OWNER_LS, 64'h8000_2000, 0, 0, 0, 64'hA000 + 64'(i), 0, 0);
            else
                txn("held_if", OWNER_IF, 64'h8000_0100, 0, 0, 0, 64'hB000 + 64'(i), 0, 0);
        end
        ls_req_valid = 1'b0; if_req_valid = 1'b0;
        settle();

        // Memory stalls the request for five cycles
        if_addr = 64'h8000_0200; if_req_valid = 1'b1;
        settle();
        txn("stall", OWNER_IF, 64'h8000_0200, 0, 0, 0, 64'hC0DE, 5, 1);

        // Reset while waiting for the response, then a stray response
        ls_addr = 64'h8000_3000; ls_wen = 1'b1; ls_wdata = 64'h1234; ls_wmask = 8'h0F;
        ls_req_valid = 1'b1;
        settle();
        chk("rstw.accept", ls_req_ready, 1);
        tick();
        ls_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        settle();
        chk("rstw.busy_in_wait", busy, 1);
        rst = 1'b1;
        settle();
        chk_zero("rstw.during");
        tick();
        rst = 1'b0;
        mem_rsp_valid = 1'b1; mem_rdata = 64'h55;
        settle();
        chk_zero("rstw.stray1");
        tick();
        settle();
        chk_zero("rstw.stray2");
        mem_rsp_valid = 1'b0; mem_rdata = '0;

        // History is back to IF after reset, so contention goes to LS
        ls_addr = 64'h8000_4000; ls_wen = 1'b1; ls_wdata = 64'hBEEF; ls_wmask = 8'hF0;
        ls_req_valid = 1'b1;
        if_addr = 64'h8000_0300; if_req_valid = 1'b1;
        settle();
        txn("post_rst", OWNER_LS, 64'h8000_4000, 1, 64'hBEEF, 8'hF0, 64'h77, 1, 1);
        if_req_valid = 1'b0;
        settle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
